// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-PC controller.
// Misalign trapping is enabled by defining PC_FETCH_CTRL_MISALIGN_CHK_EN.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_JMP  = 2'd2
  } redir_src_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_ctrl_redirect_arb.sv
// Combinational priority select between the EX branch and the ID jump redirect.
module pc_redirect_arb
  import pc_fetch_ctrl_pkg::*;
(
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  output logic        redir_vld_o,
  output redir_src_e  redir_src_o,
  output logic [31:0] tgt_o
);

  // Branch outranks jump: it resolves in an older instruction.
  always_comb begin
    redir_vld_o = 1'b0;
    redir_src_o = REDIR_NONE;
    tgt_o       = jmp_target_i;
    if (br_taken_i) begin
      redir_vld_o = 1'b1;
      redir_src_o = REDIR_BR;
      tgt_o       = br_target_i;
    end else if (jmp_i) begin
      redir_vld_o = 1'b1;
      redir_src_o = REDIR_JMP;
      tgt_o       = jmp_target_i;
    end else begin
      redir_vld_o = 1'b0;
      redir_src_o = REDIR_NONE;
      tgt_o       = jmp_target_i;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-PC sequencer: IM request handshake, 1-entry instruction buffer, redirect/kill.
// Optional misaligned-target trap: define PC_FETCH_CTRL_MISALIGN_CHK_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
`ifdef PC_FETCH_CTRL_MISALIGN_CHK_EN
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
`endif
  parameter int          IM_AW    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  input  logic             jmp_i,
  input  logic [31:0]      jmp_target_i,
  output logic             im_req_o,
  output logic [IM_AW-1:0] im_addr_o,
  input  logic             im_gnt_i,
  input  logic             im_rvalid_i,
  input  logic [31:0]      im_rdata_i,
  output logic             inst_valid_o,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_pc_o,
  output logic             misalign_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;
  logic         kill_q;
  logic         inst_valid_q;
  logic [31:0]  inst_q;
  logic [31:0]  inst_pc_q;

  logic         arb_vld_s;
  redir_src_e   redir_src_s;
  logic [31:0]  tgt_s;
  logic         redir_s;
  logic [31:0]  redir_pc_d;
  logic         misalign_d;

  pc_redirect_arb u_arb (
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .redir_vld_o  (arb_vld_s),
    .redir_src_o  (redir_src_s),
    .tgt_o        (tgt_s)
  );

  // Source and valid must agree before a redirect is honoured.
  assign redir_s = arb_vld_s && (redir_src_s != REDIR_NONE);

  always_comb begin
    redir_pc_d = tgt_s & 32'hFFFF_FFFC;
    misalign_d = 1'b0;
`ifdef PC_FETCH_CTRL_MISALIGN_CHK_EN
    if (tgt_s[1:0] != 2'b00) begin
      redir_pc_d = TRAP_VEC;
      misalign_d = redir_s;
    end else begin
      redir_pc_d = tgt_s;
      misalign_d = 1'b0;
    end
`endif
  end

`ifdef PC_FETCH_CTRL_MISALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= 32'h0000_0000;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0000_0000;
      inst_pc_q    <= 32'h0000_0000;
    end else begin
      case (state_q)
        FETCH: begin
          if (redir_s) begin
            pc_q <= redir_pc_d;
            if (im_gnt_i) begin
              kill_q  <= 1'b1;
              state_q <= WAIT;
            end
          end else if (im_gnt_i) begin
            fetch_pc_q <= pc_q;
            pc_q       <= pc_q + PC_STEP;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // A redirect always wins over returned data; a later target overwrites pc.
          if (redir_s) begin
            pc_q <= redir_pc_d;
            if (im_rvalid_i) begin
              kill_q  <= 1'b0;
              state_q <= FETCH;
            end else begin
              kill_q <= 1'b1;
            end
          end else if (im_rvalid_i) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= FETCH;
            end else begin
              inst_q       <= im_rdata_i;
              inst_pc_q    <= fetch_pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redir_s) begin
            inst_valid_q <= 1'b0;
            pc_q         <= redir_pc_d;
            state_q      <= FETCH;
          end else if (!stall_i) begin
            inst_valid_q <= 1'b0;
            state_q      <= FETCH;
          end
        end
        default: begin
          state_q      <= FETCH;
          kill_q       <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign im_req_o     = (state_q == FETCH) && rst;
  assign im_addr_o    = pc_q[IM_AW+1:2];
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios then random traffic vs a transaction model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = 32'd0;
  logic        jmp_i = 1'b0;
  logic [31:0] jmp_target_i = 32'd0;
  logic        im_req_o;
  logic [13:0] im_addr_o;
  logic        im_gnt_i = 1'b0;
  logic        im_rvalid_i = 1'b0;
  logic [31:0] im_rdata_i = 32'd0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .im_req_o     (im_req_o),
    .im_addr_o    (im_addr_o),
    .im_gnt_i     (im_gnt_i),
    .im_rvalid_i  (im_rvalid_i),
    .im_rdata_i   (im_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .misalign_o   (misalign_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction-level model: next pc, one outstanding request, one buffered instruction.
  logic [31:0] m_pc = 32'd0;
  bit          m_busy = 1'b0;
  bit          m_dead = 1'b0;
  logic [31:0] m_fpc = 32'd0;
  bit          m_buf = 1'b0;
  logic [31:0] m_inst = 32'd0;
  logic [31:0] m_ipc = 32'd0;
  bit          m_mis = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          redir;
    bit          mis;
    redir = br_taken_i || jmp_i;
    tgt   = br_taken_i ? br_target_i : jmp_target_i;
    mis   = 1'b0;
`ifdef PC_FETCH_CTRL_MISALIGN_CHK_EN
    if ((tgt % 32'd4) != 32'd0) begin
      tgt = 32'h0000_0100;
      mis = redir;
    end
`else
    tgt = tgt - (tgt % 32'd4);
`endif
    if (!rst) begin
      m_pc = 32'd0; m_busy = 1'b0; m_dead = 1'b0; m_buf = 1'b0;
      m_inst = 32'd0; m_ipc = 32'd0; m_mis = 1'b0;
      return;
    end
    m_mis = mis;
    if (m_buf) begin
      if (redir || !stall_i) m_buf = 1'b0;
      if (redir) m_pc = tgt;
    end else if (m_busy) begin
      if (redir) begin
        m_pc = tgt;
        if (im_rvalid_i) begin m_busy = 1'b0; m_dead = 1'b0; end
        else m_dead = 1'b1;
      end else if (im_rvalid_i) begin
        m_busy = 1'b0;
        if (!m_dead) begin m_buf = 1'b1; m_inst = im_rdata_i; m_ipc = m_fpc; end
        m_dead = 1'b0;
      end
    end else begin
      if (im_gnt_i) begin m_busy = 1'b1; m_dead = redir; m_fpc = m_pc; m_pc = m_pc + 32'd4; end
      if (redir) m_pc = tgt;
    end
  endtask

  task automatic check_all();
    chk("im_req",     32'(im_req_o),     32'(!m_busy && !m_buf && rst));
    chk("im_addr",    32'(im_addr_o),    (m_pc >> 2) & 32'h3FFF);
    chk("inst_valid", 32'(inst_valid_o), 32'(m_buf));
    chk("inst",       inst_o,            m_inst);
    chk("inst_pc",    inst_pc_o,         m_ipc);
    chk("misalign",   32'(misalign_o),   32'(m_mis));
  endtask

  task automatic cyc(input logic r, input logic st, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic g, input logic rv);
    @(negedge clk);
    rst = r; stall_i = st; br_taken_i = b; br_target_i = bt;
    jmp_i = j; jmp_target_i = jt; im_gnt_i = g; im_rvalid_i = rv;
    im_rdata_i = $urandom;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    // Reset
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("rst_req",   32'(im_req_o),     32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);

    // Zero-wait stream: 3 instructions at pc 0,4,8
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("stream_next_addr", 32'(im_addr_o), 32'd3);

    // Stall in HOLD for 5 cycles
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
      chk("stall_req", 32'(im_req_o), 32'd0);
      chk("stall_pc",  inst_pc_o,     32'h0000_000C);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("unstall_req", 32'(im_req_o), 32'd1);

    // Jump during WAIT kills the returned word
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("kill_valid", 32'(inst_valid_o), 32'd0);
    chk("kill_addr",  32'(im_addr_o),    32'h10);

    // Branch and jump together with gnt: branch wins, fetch killed
    cyc(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 1'b0);
    chk("prio_addr", 32'(im_addr_o), 32'h20);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("prio_valid", 32'(inst_valid_o), 32'd0);

    // Misaligned redirect target
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h42, 1'b0, 1'b0);
`ifdef PC_FETCH_CTRL_MISALIGN_CHK_EN
    chk("mis_addr",  32'(im_addr_o),  32'h40);
    chk("mis_pulse", 32'(misalign_o), 32'd1);
`else
    chk("mis_addr",  32'(im_addr_o),  32'h10);
    chk("mis_pulse", 32'(misalign_o), 32'd0);
`endif
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("mis_clear", 32'(misalign_o), 32'd0);

    // Reset during WAIT, stale rvalid afterwards
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("stale_addr",  32'(im_addr_o),    32'd0);
    chk("stale_valid", 32'(inst_valid_o), 32'd0);
    chk("stale_req",   32'(im_req_o),     32'd1);

    // PC wrap at top of address space
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("wrap_addr", 32'(im_addr_o), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("wrap_inst_pc", inst_pc_o, 32'hFFFF_FFFC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) != 0), ($urandom_range(1) == 1),
          ($urandom_range(15) == 0), $urandom,
          ($urandom_range(15) == 0), $urandom,
          ($urandom_range(1) == 1), ($urandom_range(9) < 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
